// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// Circular-buffer FIFO controller in front of a 64x8 dual-port RAM with
// asynchronous read. Port A of the RAM is the write side and port B the read
// side. Upstream and downstream logic see a plain FIFO with full/empty flags,
// an occupancy count and sticky overflow/underflow flags. The asynchronous RAM
// read is registered to give a one-cycle-latency read output.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DATA_WIDTH-1:0] ram_data_in_A,
    output logic [ADDR_WIDTH-1:0] ram_addr_A,
    output logic                  ram_mode_A,
    output logic [DATA_WIDTH-1:0] ram_data_in_B,
    output logic [ADDR_WIDTH-1:0] ram_addr_B,
    output logic                  ram_mode_B,
    input  logic [DATA_WIDTH-1:0] ram_data_out_B
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the address bits are equal.
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_rd_accept;

    // Status decode from the registered pointers only.
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                  (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
    end

    // Request acceptance: a write while full is allowed only alongside a read,
    // and a read while empty is always rejected (no fall-through).
    // NOTE: the accepts are gated with rst_n so the combinational RAM write
    // strobe stays low during reset cycles; otherwise a write requested while
    // in reset would corrupt the RAM even though the pointers ignore it.
    always_comb begin
        w_wr_accept = rst_n & wr_en & (~w_full | rd_en);
        w_rd_accept = rst_n & rd_en & ~w_empty;
    end

    // Pointer advance; both wrap naturally at 2**(ADDR_WIDTH+1).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_accept) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Register the asynchronous RAM read word on each accepted pop. The RAM is
    // written on the same edge, so a pop while full captures the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) r_rd_data <= ram_data_out_B;
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wr_accept) r_overflow  <= 1'b1;
            if (rd_en && w_empty)      r_underflow <= 1'b1;
        end
    end

    // Output and RAM-side wiring. RAM contents are deliberately not cleared
    // on reset: after reset empty=1, so stale words can never be popped.
    always_comb begin
        rd_data       = r_rd_data;
        rd_valid      = r_rd_valid;
        full          = w_full;
        empty         = w_empty;
        count         = r_wr_ptr - r_rd_ptr;
        overflow      = r_overflow;
        underflow     = r_underflow;
        ram_data_in_A = wr_data;
        ram_addr_A    = r_wr_ptr[ADDR_WIDTH-1:0];
        ram_mode_A    = w_wr_accept;
        ram_data_in_B = '0;
        ram_addr_B    = r_rd_ptr[ADDR_WIDTH-1:0];
        ram_mode_B    = 1'b0;
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl
// Self-checking bench: a behavioural 64x8 RAM closes the loop around the
// controller, and a queue-based FIFO model predicts every output.
module tb_dpram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [DW-1:0] ram_data_in_A;
    logic [AW-1:0] ram_addr_A;
    logic          ram_mode_A;
    logic [DW-1:0] ram_data_in_B;
    logic [AW-1:0] ram_addr_B;
    logic          ram_mode_B;
    logic [DW-1:0] ram_data_out_B;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .underflow      (underflow),
        .ram_data_in_A  (ram_data_in_A),
        .ram_addr_A     (ram_addr_A),
        .ram_mode_A     (ram_mode_A),
        .ram_data_in_B  (ram_data_in_B),
        .ram_addr_B     (ram_addr_B),
        .ram_mode_B     (ram_mode_B),
        .ram_data_out_B (ram_data_out_B)
    );

    // Behavioural dual-port RAM: synchronous write on port A, async read on B.
    logic [DW-1:0] mem [DEPTH];
    initial for (int k = 0; k < DEPTH; k++) mem[k] = 8'hEE;
    always @(posedge clk) if (ram_mode_A) mem[ram_addr_A] <= ram_data_in_A;
    assign ram_data_out_B = mem[ram_addr_B];

    // Reference model state.
    logic [7:0]  q[$];
    int unsigned wr_total;
    int unsigned rd_total;
    logic [7:0]  m_rd_data;
    bit          m_rd_valid;
    bit          m_ovf;
    bit          m_unf;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wr_total   = 0;
        rd_total   = 0;
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
    endtask

    task automatic check_state();
        check("rd_valid",  rd_valid,  m_rd_valid);
        check("rd_data",   rd_data,   m_rd_data);
        check("count",     count,     q.size());
        check("full",      full,      q.size() == DEPTH);
        check("empty",     empty,     q.size() == 0);
        check("overflow",  overflow,  m_ovf);
        check("underflow", underflow, m_unf);
    endtask

    // One normal clock cycle with the given requests.
    task automatic cycle(input bit we, input logic [7:0] wd, input bit re);
        bit wacc;
        bit racc;
        rst_n   = 1'b1;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        #1;
        wacc = we && ((q.size() != DEPTH) || re);
        racc = re && (q.size() != 0);
        check("ram_mode_A",    ram_mode_A,    wacc);
        check("ram_addr_A",    ram_addr_A,    wr_total % DEPTH);
        check("ram_data_in_A", ram_data_in_A, wd);
        check("ram_addr_B",    ram_addr_B,    rd_total % DEPTH);
        check("ram_mode_B",    ram_mode_B,    0);
        check("ram_data_in_B", ram_data_in_B, 0);
        @(posedge clk);
        #1;
        if (racc) begin
            m_rd_data  = q.pop_front();
            m_rd_valid = 1'b1;
            rd_total++;
        end else begin
            m_rd_valid = 1'b0;
        end
        if (wacc) begin
            q.push_back(wd);
            wr_total++;
        end
        if (we && !wacc) m_ovf = 1'b1;
        if (re && !racc) m_unf = 1'b1;
        check_state();
    endtask

    // One reset cycle; requests presented during it must be ignored.
    task automatic reset_cycle(input bit we, input bit re);
        rst_n   = 1'b0;
        wr_en   = we;
        wr_data = 8'($urandom);
        rd_en   = re;
        #1;
        check("rst_mode_A", ram_mode_A, 0);
        @(posedge clk);
        #1;
        model_reset();
        check_state();
    endtask

    initial begin
        model_reset();

        // Reset held two cycles with both requests high.
        reset_cycle(1'b1, 1'b1);
        reset_cycle(1'b1, 1'b1);

        // Fill with i+5, then one rejected write.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i + 5), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);

        // Drain in order, then one rejected read.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Wrap-around.
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(i + 100), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);

        // Simultaneous read and write at full, then at empty.
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 8'h77, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h09, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Mid-stream reset with 20 words stored.
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i + 200), 1'b0);
        reset_cycle(1'b1, 1'b1);
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Randomized traffic with alternating fill/drain bias and rare resets.
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            int unsigned p_wr;
            int unsigned p_rd;
            p_wr = ((i % 400) < 200) ? 75 : 35;
            p_rd = ((i % 400) < 200) ? 35 : 75;
            if ($urandom_range(0, 249) == 0)
                reset_cycle(1'($urandom), 1'($urandom));
            else
                cycle($urandom_range(0, 99) < p_wr, 8'($urandom),
                      $urandom_range(0, 99) < p_rd);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
